regfile_scoreboard: RTL and testbench

- Parametrised register file with per-register write-reservation scoreboard; it sits between the decode stage (operand reads, destination reservation) and the exec/writeback stage.
- Generalises the fixed 4-entry, single-reservation file: configurable register count and width, multiple outstanding writes per register, optional writeback bypass, optional hardwired zero register.
- Supplies operand data plus per-operand ready flags, from which decode derives its stall.

---
 rtl/regfile_scoreboard_pkg.sv | 17 +
 rtl/regfile_scoreboard_entry.sv | 48 ++++
 rtl/regfile_scoreboard.sv | 132 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and width helpers for the scoreboarded register file.
package regfile_scoreboard_pkg;

  // Index of the optional hardwired-zero register.
  localparam int unsigned ZeroRegIdx = 0;

  // Selector width; a single-register file still needs a one-bit selector.
  function automatic int unsigned sel_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Pending-write counter width, wide enough to hold max_pend itself.
  function automatic int unsigned cnt_width(input int unsigned max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_entry.sv
// One architectural register: stored value plus outstanding-write counter.
module regfile_scoreboard_entry #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CW     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     cnt_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Simultaneous reserve and writeback cancel out on the counter; data always takes the write.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (dec_i) begin
      data_d = wdata_i;
    end
  end

  // Entry state with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register write-reservation scoreboard, optional writeback bypass
// and optional hardwired zero register. Decode reads operands/ready flags and reserves
// destinations; writeback retires reservations.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS    = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned AW      = sel_width(NREGS),
  localparam int unsigned CW      = cnt_width(MAX_PEND)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_sel_i,
  input  logic [AW-1:0]     rs_sel_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic              rd_ready_o,
  output logic              rs_ready_o,
  input  logic              res_valid_i,
  input  logic [AW-1:0]     res_sel_i,
  output logic              res_ok_o,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_sel_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [NREGS-1:0]  busy_mask_o,
  output logic              err_wb_o
);

  localparam bit BypassEn = (BYPASS != 0);
  localparam bit ZeroEn   = (ZERO_REG != 0);
  localparam int ZeroIdx  = int'(ZeroRegIdx);

  logic [DATA_W-1:0] data_arr [NREGS];
  logic [CW-1:0]     cnt_arr  [NREGS];
  logic [NREGS-1:0]  wb_hit;
  logic [NREGS-1:0]  inc;
  logic [NREGS-1:0]  busy;
  logic              res_ok;
  logic              err_d, err_q;

  for (genvar i = 0; i < NREGS; i++) begin : r
    logic [DATA_W-1:0] data;
    logic [CW-1:0]     cnt;

    regfile_scoreboard_entry #(
      .DATA_W (DATA_W),
      .CW     (CW)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc[i]),
      .dec_i   (wb_hit[i]),
      .wdata_i (wb_data_i),
      .data_o  (data),
      .cnt_o   (cnt),
      .busy_o  (busy[i])
    );

    assign data_arr[i] = data;
    assign cnt_arr[i]  = cnt;
  end

  // A writeback only lands on a register that has an outstanding reservation.
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      wb_hit[i] = wb_valid_i && (wb_sel_i == AW'(i)) && (cnt_arr[i] != '0) &&
                  !(ZeroEn && (i == ZeroIdx));
    end
  end

  // Operand muxes; out-of-range and hardwired-zero selects fall through to zero/ready.
  always_comb begin
    rd_data_o  = '0;
    rd_ready_o = 1'b1;
    rs_data_o  = '0;
    rs_ready_o = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      if (!(ZeroEn && (i == ZeroIdx))) begin
        if (rd_sel_i == AW'(i)) begin
          rd_data_o  = (BypassEn && wb_hit[i]) ? wb_data_i : data_arr[i];
          rd_ready_o = (cnt_arr[i] == '0) ||
                       (BypassEn && wb_hit[i] && (cnt_arr[i] == CW'(1)));
        end
        if (rs_sel_i == AW'(i)) begin
          rs_data_o  = (BypassEn && wb_hit[i]) ? wb_data_i : data_arr[i];
          rs_ready_o = (cnt_arr[i] == '0) ||
                       (BypassEn && wb_hit[i] && (cnt_arr[i] == CW'(1)));
        end
      end
    end
  end

  // Reservation acceptance; a same-cycle writeback frees a slot on a full register.
  always_comb begin
    res_ok = 1'b0;
    inc    = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (res_sel_i == AW'(i)) begin
        if (ZeroEn && (i == ZeroIdx)) begin
          res_ok = 1'b1;
        end else begin
          res_ok = (cnt_arr[i] < CW'(MAX_PEND)) || wb_hit[i];
          inc[i] = res_valid_i && res_ok;
        end
      end
    end
  end

  // Flag writebacks that found no reservation; writes to a hardwired zero are silent.
  always_comb begin
    err_d = wb_valid_i && (wb_hit == '0) && !(ZeroEn && (wb_sel_i == AW'(ZeroIdx)));
  end

  // Error pulse register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign res_ok_o    = res_ok;
  assign busy_mask_o = busy;
  assign err_wb_o    = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: DUT A (4 regs, 1 pending, bypass, no zero reg) and
// DUT B (6 regs, 2 pending, no bypass, hardwired r0).
module tb_regfile_scoreboard;

  logic clk, rst;
  int   n_checks, n_fail;

  logic [1:0]  a_rd_sel, a_rs_sel, a_res_sel, a_wb_sel;
  logic [31:0] a_rd_data, a_rs_data, a_wb_data;
  logic        a_rd_ready, a_rs_ready, a_res_valid, a_res_ok, a_wb_valid, a_err;
  logic [3:0]  a_busy;

  logic [2:0]  b_rd_sel, b_rs_sel, b_res_sel, b_wb_sel;
  logic [31:0] b_rd_data, b_rs_data, b_wb_data;
  logic        b_rd_ready, b_rs_ready, b_res_valid, b_res_ok, b_wb_valid, b_err;
  logic [5:0]  b_busy;

  regfile_scoreboard #(
    .NREGS(4), .DATA_W(32), .MAX_PEND(1), .BYPASS(1), .ZERO_REG(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .rd_sel_i(a_rd_sel), .rs_sel_i(a_rs_sel),
    .rd_data_o(a_rd_data), .rs_data_o(a_rs_data),
    .rd_ready_o(a_rd_ready), .rs_ready_o(a_rs_ready),
    .res_valid_i(a_res_valid), .res_sel_i(a_res_sel), .res_ok_o(a_res_ok),
    .wb_valid_i(a_wb_valid), .wb_sel_i(a_wb_sel), .wb_data_i(a_wb_data),
    .busy_mask_o(a_busy), .err_wb_o(a_err)
  );

  regfile_scoreboard #(
    .NREGS(6), .DATA_W(32), .MAX_PEND(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .rd_sel_i(b_rd_sel), .rs_sel_i(b_rs_sel),
    .rd_data_o(b_rd_data), .rs_data_o(b_rs_data),
    .rd_ready_o(b_rd_ready), .rs_ready_o(b_rs_ready),
    .res_valid_i(b_res_valid), .res_sel_i(b_res_sel), .res_ok_o(b_res_ok),
    .wb_valid_i(b_wb_valid), .wb_sel_i(b_wb_sel), .wb_data_i(b_wb_data),
    .busy_mask_o(b_busy), .err_wb_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_res_valid = 1'b0; a_wb_valid = 1'b0; a_res_sel = '0; a_wb_sel = '0; a_wb_data = '0;
    b_res_valid = 1'b0; b_wb_valid = 1'b0; b_res_sel = '0; b_wb_sel = '0; b_wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_rd_sel = '0; a_rs_sel = '0; b_rd_sel = '0; b_rs_sel = '0;
    idle();
    step();
    step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      a_rd_sel = 2'(i);
      a_rs_sel = 2'(3 - i);
      #1;
      n_checks++;
      if (a_rd_data !== 32'h0 || a_rs_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data r%0d: got rd=%h rs=%h want 0", i, a_rd_data, a_rs_data);
      end
      n_checks++;
      if (a_rd_ready !== 1'b1 || a_rs_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready r%0d: got rd=%b rs=%b want 1", i, a_rd_ready, a_rs_ready);
      end
    end
    n_checks++;
    if (a_busy !== 4'b0000 || b_busy !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_busy: got a=%b b=%b want 0", a_busy, b_busy);
    end
    n_checks++;
    if (a_err !== 1'b0 || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got a=%b b=%b want 0", a_err, b_err);
    end
  endtask

  task automatic test_reserve_bypass();
    a_res_valid = 1'b1; a_res_sel = 2'd2;
    #1;
    n_checks++;
    if (a_res_ok !== 1'b1) begin
      n_fail++; $display("FAIL resv_ok: got %b want 1", a_res_ok);
    end
    step();
    a_res_valid = 1'b0; a_rd_sel = 2'd2;
    #1;
    n_checks++;
    if (a_busy !== 4'b0100) begin
      n_fail++; $display("FAIL resv_busy: got %b want 0100", a_busy);
    end
    n_checks++;
    if (a_rd_ready !== 1'b0) begin
      n_fail++; $display("FAIL resv_not_ready: got %b want 0", a_rd_ready);
    end
    a_wb_valid = 1'b1; a_wb_sel = 2'd2; a_wb_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (a_rd_ready !== 1'b1 || a_rd_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL bypass: got ready=%b data=%h want 1 deadbeef", a_rd_ready, a_rd_data);
    end
    step();
    a_wb_valid = 1'b0;
    #1;
    n_checks++;
    if (a_busy !== 4'b0000) begin
      n_fail++; $display("FAIL wb_busy: got %b want 0000", a_busy);
    end
    n_checks++;
    if (a_rd_data !== 32'hDEADBEEF || a_rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_stored: got ready=%b data=%h want 1 deadbeef", a_rd_ready, a_rd_data);
    end
    n_checks++;
    if (a_err !== 1'b0) begin
      n_fail++; $display("FAIL wb_no_err: got %b want 0", a_err);
    end
  endtask

  task automatic test_full_reserve();
    a_res_valid = 1'b1; a_res_sel = 2'd1;
    #1;
    n_checks++;
    if (a_res_ok !== 1'b1) begin
      n_fail++; $display("FAIL full_first_ok: got %b want 1", a_res_ok);
    end
    step();
    n_checks++;
    if (a_res_ok !== 1'b0) begin
      n_fail++; $display("FAIL full_second_ok: got %b want 0", a_res_ok);
    end
    step();
    a_res_valid = 1'b0;
    #1;
    n_checks++;
    if (a_busy !== 4'b0010) begin
      n_fail++; $display("FAIL full_busy: got %b want 0010", a_busy);
    end
  endtask

  task automatic test_res_wb_same_cycle();
    a_res_valid = 1'b1; a_res_sel = 2'd1;
    a_wb_valid = 1'b1; a_wb_sel = 2'd1; a_wb_data = 32'h5;
    a_rd_sel = 2'd1;
    #1;
    n_checks++;
    if (a_res_ok !== 1'b1) begin
      n_fail++; $display("FAIL same_res_ok: got %b want 1", a_res_ok);
    end
    n_checks++;
    if (a_rd_ready !== 1'b1 || a_rd_data !== 32'h5) begin
      n_fail++;
      $display("FAIL same_bypass: got ready=%b data=%h want 1 5", a_rd_ready, a_rd_data);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (a_busy !== 4'b0010 || a_rd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cnt: got busy=%b ready=%b want 0010 0", a_busy, a_rd_ready);
    end
    n_checks++;
    if (a_rd_data !== 32'h5) begin
      n_fail++; $display("FAIL same_data: got %h want 5", a_rd_data);
    end
    a_wb_valid = 1'b1; a_wb_sel = 2'd1; a_wb_data = 32'h77;
    step();
    idle();
    #1;
    n_checks++;
    if (a_busy !== 4'b0000 || a_rd_data !== 32'h77 || a_rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_clear: got busy=%b data=%h ready=%b want 0000 77 1",
               a_busy, a_rd_data, a_rd_ready);
    end
  endtask

  task automatic test_unreserved_wb();
    a_wb_valid = 1'b1; a_wb_sel = 2'd0; a_wb_data = 32'h1234; a_rd_sel = 2'd0;
    #1;
    n_checks++;
    if (a_err !== 1'b0 || a_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL unres_pre: got err=%b data=%h want 0 0", a_err, a_rd_data);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (a_err !== 1'b1) begin
      n_fail++; $display("FAIL unres_err: got %b want 1", a_err);
    end
    n_checks++;
    if (a_rd_data !== 32'h0 || a_busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL unres_state: got data=%h busy=%b want 0 0000", a_rd_data, a_busy);
    end
    step();
    n_checks++;
    if (a_err !== 1'b0) begin
      n_fail++; $display("FAIL unres_pulse: got %b want 0", a_err);
    end
  endtask

  task automatic test_multi_pend();
    b_res_valid = 1'b1; b_res_sel = 3'd3; b_rs_sel = 3'd3;
    #1;
    n_checks++;
    if (b_res_ok !== 1'b1) begin
      n_fail++; $display("FAIL multi_ok1: got %b want 1", b_res_ok);
    end
    step();
    n_checks++;
    if (b_res_ok !== 1'b1) begin
      n_fail++; $display("FAIL multi_ok2: got %b want 1", b_res_ok);
    end
    step();
    n_checks++;
    if (b_res_ok !== 1'b0) begin
      n_fail++; $display("FAIL multi_ok3: got %b want 0", b_res_ok);
    end
    b_res_valid = 1'b0;
    b_wb_valid = 1'b1; b_wb_sel = 3'd3; b_wb_data = 32'h11;
    #1;
    n_checks++;
    if (b_busy !== 6'b001000 || b_rs_ready !== 1'b0 || b_rs_data !== 32'h0) begin
      n_fail++;
      $display("FAIL multi_nobypass: got busy=%b ready=%b data=%h want 001000 0 0",
               b_busy, b_rs_ready, b_rs_data);
    end
    step();
    b_wb_data = 32'h22;
    #1;
    n_checks++;
    if (b_rs_ready !== 1'b0 || b_rs_data !== 32'h11 || b_busy !== 6'b001000) begin
      n_fail++;
      $display("FAIL multi_first_wb: got ready=%b data=%h busy=%b want 0 11 001000",
               b_rs_ready, b_rs_data, b_busy);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (b_rs_ready !== 1'b1 || b_rs_data !== 32'h22 || b_busy !== 6'b000000) begin
      n_fail++;
      $display("FAIL multi_second_wb: got ready=%b data=%h busy=%b want 1 22 000000",
               b_rs_ready, b_rs_data, b_busy);
    end
    n_checks++;
    if (b_err !== 1'b0) begin
      n_fail++; $display("FAIL multi_err: got %b want 0", b_err);
    end
  endtask

  task automatic test_zero_reg();
    b_res_valid = 1'b1; b_res_sel = 3'd0;
    b_wb_valid = 1'b1; b_wb_sel = 3'd0; b_wb_data = 32'h99; b_rd_sel = 3'd0;
    #1;
    n_checks++;
    if (b_res_ok !== 1'b1 || b_rd_data !== 32'h0 || b_rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_comb: got ok=%b data=%h ready=%b want 1 0 1",
               b_res_ok, b_rd_data, b_rd_ready);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (b_busy !== 6'b000000 || b_err !== 1'b0 || b_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_after: got busy=%b err=%b data=%h want 0 0 0",
               b_busy, b_err, b_rd_data);
    end
  endtask

  task automatic test_out_of_range();
    b_rd_sel = 3'd6; b_rs_sel = 3'd7;
    b_res_valid = 1'b1; b_res_sel = 3'd7;
    b_wb_valid = 1'b1; b_wb_sel = 3'd6; b_wb_data = 32'h55;
    #1;
    n_checks++;
    if (b_rd_data !== 32'h0 || b_rd_ready !== 1'b1 || b_rs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_read: got data=%h rdy=%b rsy=%b want 0 1 1",
               b_rd_data, b_rd_ready, b_rs_ready);
    end
    n_checks++;
    if (b_res_ok !== 1'b0) begin
      n_fail++; $display("FAIL oor_res_ok: got %b want 0", b_res_ok);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (b_err !== 1'b1 || b_busy !== 6'b000000) begin
      n_fail++; $display("FAIL oor_wb: got err=%b busy=%b want 1 0", b_err, b_busy);
    end
    step();
    n_checks++;
    if (b_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_pulse: got %b want 0", b_err);
    end
  endtask

  task automatic test_mid_reset();
    a_res_valid = 1'b1; a_res_sel = 2'd1;
    step();
    a_res_sel = 2'd2;
    step();
    a_res_valid = 1'b0;
    #1;
    n_checks++;
    if (a_busy !== 4'b0110) begin
      n_fail++; $display("FAIL mid_pre_busy: got %b want 0110", a_busy);
    end
    rst = 1'b0;
    a_res_valid = 1'b1; a_res_sel = 2'd3;
    a_wb_valid = 1'b1; a_wb_sel = 2'd1; a_wb_data = 32'hAAAA;
    step();
    rst = 1'b1;
    idle();
    #1;
    n_checks++;
    if (a_busy !== 4'b0000 || a_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_busy: got busy=%b err=%b want 0000 0", a_busy, a_err);
    end
    for (int i = 0; i < 4; i++) begin
      a_rd_sel = 2'(i);
      #1;
      n_checks++;
      if (a_rd_data !== 32'h0 || a_rd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_data r%0d: got data=%h ready=%b want 0 1", i, a_rd_data, a_rd_ready);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reserve_bypass();
    test_full_reserve();
    test_res_wb_same_cycle();
    test_unreserved_wb();
    test_multi_pend();
    test_zero_reg();
    test_out_of_range();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
